spi_word_bridge: RTL and testbench

SPI-slave front end of the matrix accelerator. It converts 16-bit SPI frames from the host MCU into word transfers on the controller's `spi_2_bus_if` bus. It also serializes result words offered by the controller on `bus_2_spi_if` back onto MISO. The block sits between the MCU SPI pins and the matrix controller, and runs entirely in the accelerator `clk` domain with oversampled SPI inputs.

---
 rtl/spi_bridge_pkg.sv | 18 +
 rtl/bus_if.sv | 11 +
 rtl/spi_sync_edge.sv | 29 ++
 rtl/spi_word_bridge.sv | 161 ++++++++++++++++
 tb/tb_spi_word_bridge.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI word bridge.
package spi_bridge_pkg;

    localparam int SPI_WORD_BITS = 16;
    localparam logic [SPI_WORD_BITS-1:0] DEFAULT_FILL_WORD = '0;

    typedef enum logic {
        RX_IDLE,
        RX_SHIFT
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_EMPTY,
        TX_FULL,
        TX_REQ
    } tx_state_t;

endpackage

// File: rtl/bus_if.sv
// Word transfer bus between the SPI bridge and the matrix controller.
interface bus_if #(
    parameter int WORD_SIZE = 16
);
    logic                 valid;
    logic                 ready;
    logic [WORD_SIZE-1:0] data;

    modport mst_port (output valid, output data);
    modport slv_port (input valid, input data, output ready);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer followed by an edge-detect flop with rise/fall pulses.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic meta, sync, prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end

    assign q    = sync;
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;
endmodule

// File: rtl/spi_word_bridge.sv
// SPI mode-0 slave that turns 16-bit frames into bus words and serializes TX words.
// Optional sticky status ports: define SPI_BRIDGE_STATUS_EN.
module spi_word_bridge
    import spi_bridge_pkg::*;
#(
    parameter int                   WORD_SIZE  = SPI_WORD_BITS,
    parameter int                   VALID_HOLD = 4,
    parameter int                   READY_HOLD = 4,
    parameter logic [WORD_SIZE-1:0] FILL_WORD  = DEFAULT_FILL_WORD
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    sclk,
    input  logic    cs_n,
    input  logic    mosi,
    output logic    miso,
    bus_if.mst_port spi_2_bus_if,
    bus_if.slv_port bus_2_spi_if
`ifdef SPI_BRIDGE_STATUS_EN
    ,
    output logic    rx_overrun,
    output logic    tx_underrun
`endif
);
    localparam int CW = $clog2(WORD_SIZE);
    localparam int VW = $clog2(VALID_HOLD + 1);
    localparam int RW = $clog2(READY_HOLD + 1);

    logic sclk_s_unused, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(sclk),
        .q(sclk_s_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .d(cs_n),
        .q(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .d(mosi),
        .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    rx_state_t            rx_state, rx_next;
    tx_state_t            tx_state, tx_next;
    logic [CW-1:0]        bit_cnt;
    logic [VW-1:0]        hold_cnt;
    logic [RW-1:0]        rdy_cnt;
    logic [WORD_SIZE-1:0] rx_shift, rx_word, rx_data, tx_hold, tx_shift;
    logic                 rx_valid, tx_ready;
    logic                 shift_en, word_done, word_accept;
    logic                 boundary, load_hold, load_fill, tx_shift_en;

    always_comb begin
        rx_next   = rx_state;
        shift_en  = 1'b0;
        word_done = 1'b0;
        case (rx_state)
            RX_IDLE: if (cs_fall) rx_next = RX_SHIFT;
            RX_SHIFT: begin
                shift_en  = sclk_rise;
                word_done = sclk_rise && (bit_cnt == CW'(WORD_SIZE - 1));
                if (cs_rise) rx_next = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
        rx_word     = {rx_shift[WORD_SIZE-2:0], mosi_s};
        word_accept = word_done && (hold_cnt == '0);
    end

    // Word completion is handled on the 16th sampled bit itself, so a cs_rise
    // arriving in the same cycle still sees the finished word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            bit_cnt  <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            hold_cnt <= '0;
        end else begin
            rx_state <= rx_next;
            if (rx_next == RX_IDLE || cs_fall) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
            end
            if (shift_en) rx_shift <= rx_word;
            if (word_accept) begin
                rx_data  <= rx_word;
                rx_valid <= 1'b1;
                hold_cnt <= VW'(VALID_HOLD);
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
                if (hold_cnt == VW'(1)) rx_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        boundary    = cs_fall || (word_done && !cs_s);
        load_hold   = boundary && (tx_state == TX_FULL);
        load_fill   = boundary && (tx_state != TX_FULL);
        tx_shift_en = sclk_fall && (rx_state == RX_SHIFT);
        tx_next     = tx_state;
        case (tx_state)
            TX_FULL: if (boundary) tx_next = TX_REQ;
            TX_REQ:  if (rdy_cnt == '0) tx_next = TX_EMPTY;
            default: tx_next = tx_state;
        endcase
        if (bus_2_spi_if.valid) tx_next = TX_FULL;
    end

    // ready is registered from the counter so it rises one cycle after the load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_EMPTY;
            tx_hold  <= '0;
            tx_shift <= '0;
            rdy_cnt  <= '0;
            tx_ready <= 1'b0;
        end else begin
            tx_state <= tx_next;
            if (bus_2_spi_if.valid) tx_hold <= bus_2_spi_if.data;
            if (load_hold) begin
                tx_shift <= tx_hold;
            end else if (load_fill) begin
                tx_shift <= FILL_WORD;
            end else if (tx_shift_en) begin
                tx_shift <= {tx_shift[WORD_SIZE-2:0], 1'b0};
            end
            if (load_hold) begin
                rdy_cnt <= RW'(READY_HOLD);
            end else if (rdy_cnt != '0) begin
                rdy_cnt <= rdy_cnt - 1'b1;
            end
            tx_ready <= (rdy_cnt != '0);
        end
    end

`ifdef SPI_BRIDGE_STATUS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            if (word_done && (hold_cnt != '0)) rx_overrun <= 1'b1;
            if (load_fill) tx_underrun <= 1'b1;
        end
    end
`endif

    assign miso               = tx_shift[WORD_SIZE-1];
    assign spi_2_bus_if.valid = rx_valid;
    assign spi_2_bus_if.data  = rx_data;
    assign bus_2_spi_if.ready = tx_ready;
endmodule

// File: tb/tb_spi_word_bridge.sv
// Self-checking bench for spi_word_bridge: vector table, random frames, corner sequences.
module tb_spi_word_bridge;
    localparam int VH = 4;
    localparam int RH = 4;
    localparam logic [15:0] FILL = 16'h0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sclk = 1'b0;
    logic cs_n = 1'b1;
    logic mosi = 1'b0;
    logic miso;
`ifdef SPI_BRIDGE_STATUS_EN
    logic rx_overrun, tx_underrun;
`endif

    bus_if #(.WORD_SIZE(16)) s2b ();
    bus_if #(.WORD_SIZE(16)) b2s ();

    spi_word_bridge #(
        .WORD_SIZE(16), .VALID_HOLD(VH), .READY_HOLD(RH), .FILL_WORD(FILL)
    ) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .spi_2_bus_if(s2b), .bus_2_spi_if(b2s)
`ifdef SPI_BRIDGE_STATUS_EN
        , .rx_overrun(rx_overrun), .tx_underrun(tx_underrun)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Bus-side observers: record each completed valid/ready pulse.
    logic [15:0] rx_q[$];
    int          rxw_q[$];
    int          rdyw_q[$];
    logic        pv = 1'b0, pr = 1'b0;
    int          vw = 0, rw = 0;
    logic [15:0] vd = '0;

    always @(negedge clk) begin
        if (s2b.valid) begin
            vw <= pv ? vw + 1 : 1;
            if (!pv) vd <= s2b.data;
        end else if (pv) begin
            rx_q.push_back(vd);
            rxw_q.push_back(vw);
        end
        pv <= s2b.valid;
        if (b2s.ready) rw <= pr ? rw + 1 : 1;
        else if (pr) rdyw_q.push_back(rw);
        pr <= b2s.ready;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        rx_q.delete();
        rxw_q.delete();
        rdyw_q.delete();
    endtask

    task automatic offer(input logic [15:0] w);
        b2s.valid = 1'b1;
        b2s.data  = w;
        clks(1);
        b2s.valid = 1'b0;
        clks(2);
    endtask

    task automatic shift_bits(input logic [15:0] w, input int n, output logic [15:0] mi);
        mi = '0;
        for (int i = 0; i < n; i++) begin
            mosi = w[15-i];
            clks(8);
            mi = {mi[14:0], miso};
            sclk = 1'b1;
            clks(8);
            sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [15:0] w, output logic [15:0] mi);
        cs_n = 1'b0;
        clks(8);
        shift_bits(w, 16, mi);
        clks(8);
        cs_n = 1'b1;
        clks(24);
    endtask

    typedef struct {
        logic [15:0] mosi_w;
        int          n_tx;
        logic [15:0] tx0;
        logic [15:0] tx1;
        logic [15:0] exp_rx;
        logic [15:0] exp_miso;
        int          exp_rdy;
    } vec_t;

    task automatic apply_vec(input vec_t v, input string tag);
        logic [15:0] mi;
        clear_obs();
        if (v.n_tx > 0) offer(v.tx0);
        if (v.n_tx > 1) offer(v.tx1);
        run_frame(v.mosi_w, mi);
        chk({tag, " valid pulses"}, rx_q.size(), 1);
        if (rx_q.size() > 0) begin
            chk({tag, " rx data"}, rx_q[0], v.exp_rx);
            chk({tag, " valid width"}, rxw_q[0], VH);
        end
        chk({tag, " miso word"}, mi, v.exp_miso);
        chk({tag, " ready pulses"}, rdyw_q.size(), v.exp_rdy);
        if (v.exp_rdy > 0 && rdyw_q.size() > 0) chk({tag, " ready width"}, rdyw_q[0], RH);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[5];
        vec_t        v;
        logic [15:0] mi;

        tbl[0] = '{16'h4003, 0, 16'h0000, 16'h0000, 16'h4003, 16'h0000, 0};
        tbl[1] = '{16'h1357, 1, 16'hBEEF, 16'h0000, 16'h1357, 16'hBEEF, 1};
        tbl[2] = '{16'hFFFF, 1, 16'h0001, 16'h0000, 16'hFFFF, 16'h0001, 1};
        tbl[3] = '{16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0};
        tbl[4] = '{16'h8001, 2, 16'h1111, 16'h8000, 16'h8001, 16'h8000, 1};

        s2b.ready = 1'b0;
        b2s.valid = 1'b0;
        b2s.data  = '0;
        clks(4);
        chk("reset valid", s2b.valid, 0);
        chk("reset data", s2b.data, 0);
        chk("reset ready", b2s.ready, 0);
        chk("reset miso", miso, 0);
        reset = 1'b0;
        clks(8);

        for (int i = 0; i < 5; i++) begin
            apply_vec(tbl[i], $sformatf("tbl%0d", i));
`ifdef SPI_BRIDGE_STATUS_EN
            if (i == 0) chk("underrun after empty frame", tx_underrun, 1);
`endif
        end

        // Two words under a single chip select.
        clear_obs();
        cs_n = 1'b0;
        clks(8);
        shift_bits(16'h5001, 16, mi);
        shift_bits(16'h1234, 16, mi);
        clks(8);
        cs_n = 1'b1;
        clks(24);
        chk("multi pulses", rx_q.size(), 2);
        if (rx_q.size() >= 2) begin
            chk("multi word0", rx_q[0], 16'h5001);
            chk("multi word1", rx_q[1], 16'h1234);
        end

        // Partial frame is discarded.
        clear_obs();
        cs_n = 1'b0;
        clks(8);
        shift_bits(16'h9C3E, 9, mi);
        clks(8);
        cs_n = 1'b1;
        clks(24);
        chk("partial no valid", rx_q.size(), 0);
        v = '{16'hA5A5, 0, 16'h0000, 16'h0000, 16'hA5A5, FILL, 0};
        apply_vec(v, "after partial");

        // Randomized frames against the last-write-wins TX model.
        for (int k = 0; k < 16; k++) begin
            v.mosi_w   = 16'($urandom);
            v.n_tx     = $urandom_range(0, 2);
            v.tx0      = 16'($urandom);
            v.tx1      = 16'($urandom);
            v.exp_rx   = v.mosi_w;
            v.exp_miso = (v.n_tx == 0) ? FILL : (v.n_tx == 1 ? v.tx0 : v.tx1);
            v.exp_rdy  = (v.n_tx > 0) ? 1 : 0;
            apply_vec(v, $sformatf("rnd%0d", k));
        end

        // Reset in the middle of a frame.
        clear_obs();
        offer(16'hFFFF);
        cs_n = 1'b0;
        clks(8);
        shift_bits(16'h3C3C, 7, mi);
        clks(4);
        chk("pre-reset miso", miso, 1);
        reset = 1'b1;
        #1;
        chk("async reset valid", s2b.valid, 0);
        chk("async reset data", s2b.data, 0);
        chk("async reset ready", b2s.ready, 0);
        chk("async reset miso", miso, 0);
        cs_n = 1'b1;
        sclk = 1'b0;
        clks(3);
        reset = 1'b0;
        clks(8);
        v = '{16'h0F0F, 0, 16'h0000, 16'h0000, 16'h0F0F, FILL, 0};
        apply_vec(v, "post-reset");
`ifdef SPI_BRIDGE_STATUS_EN
        chk("no overrun", rx_overrun, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
